// File: rtl/sram_multi_loader_pkg.sv
// sram_multi_loader_pkg: FSM encoding, SRAM memory map and default channel layout for the loader
package sram_multi_loader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int SRAM_ADDR_W = 17;
  localparam int RF_ADDR_W = 10;
  localparam logic [SRAM_ADDR_W-1:0] INPUT_BASE = 17'h100;
  localparam logic [SRAM_ADDR_W-1:0] LABEL_BASE = 17'h200;
  localparam logic [RF_ADDR_W-1:0] INPUT_LEN = 10'd2;
  localparam logic [RF_ADDR_W-1:0] LABEL_LEN = 10'd4;
  localparam logic [2*SRAM_ADDR_W-1:0] DEF_CH_BASE = {LABEL_BASE, INPUT_BASE};
  localparam logic [2*RF_ADDR_W-1:0] DEF_CH_LEN = {LABEL_LEN, INPUT_LEN};
endpackage

// File: rtl/sram_multi_loader_if.sv
// sram_multi_loader_if: control handshake, SRAM read port and register-file write port
// LOADER_ABORT_EN adds the abort/aborted pair.
interface sram_multi_loader_if #(
  parameter int ADDR_W = 17,
  parameter int RA_W = 10,
  parameter int NUM_CH = 2,
  parameter int IDX_W = 8
);
  logic start;
  logic [IDX_W-1:0] sample_idx;
  logic busy, done;
  logic [ADDR_W-1:0] sram_addr;
  logic sram_cs_n, sram_oe_n, sram_we_n, sram_data_output_en;
  logic [RA_W-1:0] wa;
  logic [NUM_CH-1:0] we;
`ifdef LOADER_ABORT_EN
  logic abort, aborted;
  modport master (input start, sample_idx, abort,
                  output busy, done, aborted, sram_addr, sram_cs_n, sram_oe_n, sram_we_n, sram_data_output_en, wa, we);
  modport slave (output start, sample_idx, abort,
                 input busy, done, aborted, sram_addr, sram_cs_n, sram_oe_n, sram_we_n, sram_data_output_en, wa, we);
`else
  modport master (input start, sample_idx,
                  output busy, done, sram_addr, sram_cs_n, sram_oe_n, sram_we_n, sram_data_output_en, wa, we);
  modport slave (output start, sample_idx,
                 input busy, done, sram_addr, sram_cs_n, sram_oe_n, sram_we_n, sram_data_output_en, wa, we);
`endif
endinterface

// File: rtl/sram_multi_loader_delay_line.sv
// loader_delay_line: LAT-deep {valid, payload} shift register aligning write strobes with SRAM read data
module loader_delay_line #(
  parameter int LAT = 1,
  parameter int W = 1
) (
  input logic clk,
  input logic clr,
  input logic in_v,
  input logic [W-1:0] in_d,
  output logic out_v,
  output logic [W-1:0] out_d,
  output logic pending
);
  localparam logic [LAT-1:0] LAST = LAT'(1) << (LAT - 1);
  logic [LAT-1:0] v;
  logic [W-1:0] d [LAT];
  always_ff @(posedge clk) begin
    v <= clr ? '0 : (v << 1) | LAT'(in_v);
    d[0] <= in_d;
    for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
  end
  assign out_v = v[LAT-1];
  assign out_d = d[LAT-1];
  // entries still in flight behind the one leaving this cycle
  assign pending = |(v & ~LAST);
endmodule

// File: rtl/sram_multi_loader.sv
// sram_multi_loader: copies NUM_CH SRAM regions, offset by a sample index, into register files
// Defining LOADER_ABORT_EN adds the abort input and aborted pulse.
module sram_multi_loader
  import sram_multi_loader_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int RA_W = RF_ADDR_W,
  parameter int NUM_CH = 2,
  parameter int IDX_W = 8,
  parameter int SRAM_LAT = 1,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = DEF_CH_BASE,
  parameter logic [NUM_CH*RA_W-1:0] CH_LEN = DEF_CH_LEN
) (
  input logic clk,
  input logic reset,
  sram_multi_loader_if.master io
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int P_W = IDX_W + RA_W;
  function automatic logic [ADDR_W-1:0] base_of(input int c);
    return c < NUM_CH ? CH_BASE[c*ADDR_W +: ADDR_W] : '0;
  endfunction
  function automatic logic [RA_W-1:0] len_of(input int c);
    return c < NUM_CH ? CH_LEN[c*RA_W +: RA_W] : '0;
  endfunction
  function automatic logic lens_ok();
    for (int c = 0; c < NUM_CH; c++) if (len_of(c) == '0) return 1'b0;
    return 1'b1;
  endfunction
  if (NUM_CH < 1 || NUM_CH > 8 || SRAM_LAT < 1 || SRAM_LAT > 4 || !lens_ok()) begin : g_bad
    $error("sram_multi_loader: NUM_CH 1..8, SRAM_LAT 1..4 and nonzero CH_LEN entries required");
  end
  state_t state, state_n;
  logic [CH_W-1:0] ch, d_ch;
  logic [RA_W-1:0] el, d_el, wa_q;
  logic [ADDR_W-1:0] addr, nxt, tgt;
  logic [IDX_W-1:0] idx, m_idx;
  logic [P_W-1:0] prod;
  logic rdy, issue, last_el, last_ch, accept, d_v, pending, abort_now;
  int m_ch;
  assign issue = state == ISSUE;
  assign accept = state == IDLE && io.start;
  assign last_el = el == len_of(int'(ch)) - RA_W'(1);
  assign last_ch = ch == CH_W'(NUM_CH - 1);
  // shared multiplier: channel 0 at start, then one or two channels ahead of ch
  assign m_idx = issue ? idx : io.sample_idx;
  assign m_ch = issue ? int'(ch) + (rdy ? 2 : 1) : 0;
  assign prod = P_W'(m_idx) * P_W'(len_of(m_ch));
  assign tgt = base_of(m_ch) + ADDR_W'(prod);
`ifdef LOADER_ABORT_EN
  logic aborted_q;
  assign abort_now = io.abort && (state == ISSUE || state == DRAIN);
  always_ff @(posedge clk) aborted_q <= !reset && abort_now;
  assign io.aborted = aborted_q;
`else
  assign abort_now = 1'b0;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = ISSUE;
    if (issue && last_el && last_ch) state_n = DRAIN;
    if (state == DRAIN && !pending) state_n = DONE;
    if (state == DONE) state_n = IDLE;
    if (abort_now) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ch <= '0;
      el <= '0;
      addr <= '0;
      nxt <= '0;
      idx <= '0;
      rdy <= 1'b0;
      wa_q <= '0;
    end else begin
      if (d_v) wa_q <= d_el;
      if (accept) begin
        idx <= io.sample_idx;
        ch <= '0;
        el <= '0;
        addr <= tgt;
        rdy <= 1'b0;
      end else if (issue) begin
        if (!last_el) begin
          el <= el + 1'b1;
          addr <= addr + 1'b1;
        end else if (!last_ch) begin
          ch <= ch + 1'b1;
          el <= '0;
          addr <= rdy ? nxt : tgt;
        end
        // refill nxt when it is empty mid-channel, or when a switch just consumed it
        if (rdy == last_el) begin
          nxt <= tgt;
          rdy <= 1'b1;
        end
      end
    end
  end
  loader_delay_line #(.LAT(SRAM_LAT), .W(CH_W + RA_W)) u_dl (
    .clk(clk),
    .clr(reset || abort_now),
    .in_v(issue),
    .in_d({ch, el}),
    .out_v(d_v),
    .out_d({d_ch, d_el}),
    .pending(pending)
  );
  assign io.sram_addr = issue ? addr : '0;
  assign io.sram_cs_n = !issue;
  assign io.sram_oe_n = !issue;
  assign io.sram_we_n = 1'b1;
  assign io.sram_data_output_en = 1'b0;
  assign io.we = d_v ? NUM_CH'(1) << d_ch : '0;
  assign io.wa = d_v ? d_el : wa_q;
  assign io.busy = state == ISSUE || state == DRAIN;
  assign io.done = state == DONE;
endmodule
